// File: rtl/mmio_responder.sv
// MEM-stage I/O responder: debounced switches, sticky button events, LED/HEX registers and a
// 64-bit cycle timer, with combinational same-cycle read data.
module mmio_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_8000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_byte_sel,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  input  logic [15:0] i_switches,
  input  logic [3:0]  i_buttons,
  output logic        o_hit,
  output logic [31:0] o_read_data,
  output logic [15:0] o_led,
  output logic [31:0] o_hex_out
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Bits [15:0] are switches, [19:16] are buttons.
  logic [19:0]     r_sync1, r_sync2, r_samp, r_db;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_btn_evt;
  logic [15:0]     r_led;
  logic [31:0]     r_hex;
  logic [63:0]     r_timer;
  logic [31:0]     r_cyc_hi_snap;

  logic            w_tick;
  logic [19:0]     w_agree, w_db_d;
  logic [2:0]      w_idx;
  logic            w_wr, w_rd;
  logic [31:0]     w_led_merged, w_hex_merged;
  logic [3:0]      w_btn_evt_d;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sel, input logic [1:0] lane);
    logic [31:0] res;
    res = old;
    case (sel)
      2'b01: begin
        if (lane[1]) res[31:16] = wd[15:0];
        else         res[15:0]  = wd[15:0];
      end
      2'b10: begin
        for (int b = 0; b < 4; b++) begin
          if (lane == 2'(b)) res[8*b +: 8] = wd[7:0];
        end
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  assign o_hit  = (i_address[31:5] == BASE_ADDR[31:5]);
  assign w_idx  = i_address[4:2];
  assign w_wr   = i_mem_write & o_hit;
  assign w_rd   = i_mem_read & o_hit;
  assign w_tick = (r_cnt == CntMax);

  // A bit only moves when the new sample matches the one taken on the previous tick.
  assign w_agree = ~(r_samp ^ r_sync2);
  assign w_db_d  = w_tick ? ((r_db & ~w_agree) | (r_sync2 & w_agree)) : r_db;

  // Set wins over clear-on-read so a rise coinciding with a read is kept.
  assign w_btn_evt_d = (r_btn_evt & ~{4{w_rd && (w_idx == 3'd1)}}) |
                       (w_db_d[19:16] & ~r_db[19:16]);

  assign w_led_merged = merge({16'h0000, r_led}, i_write_data, i_byte_sel, i_address[1:0]);
  assign w_hex_merged = merge(r_hex, i_write_data, i_byte_sel, i_address[1:0]);

  always_comb begin
    o_read_data = 32'h0;
    if (o_hit) begin
      case (w_idx)
        3'd0:    o_read_data = {16'h0000, r_db[15:0]};
        3'd1:    o_read_data = {28'h0, r_btn_evt};
        3'd2:    o_read_data = {16'h0000, r_led};
        3'd3:    o_read_data = r_hex;
        3'd4:    o_read_data = r_timer[31:0];
        3'd5:    o_read_data = r_cyc_hi_snap;
        default: o_read_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_samp        <= '0;
      r_db          <= '0;
      r_cnt         <= '0;
      r_btn_evt     <= '0;
      r_led         <= '0;
      r_hex         <= '0;
      r_timer       <= '0;
      r_cyc_hi_snap <= '0;
    end else begin
      r_sync1   <= {i_buttons, i_switches};
      r_sync2   <= r_sync1;
      r_cnt     <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_samp <= r_sync2;
      r_db      <= w_db_d;
      r_btn_evt <= w_btn_evt_d;
      r_timer   <= r_timer + 64'd1;
      if (w_wr && (w_idx == 3'd2)) r_led <= w_led_merged[15:0];
      if (w_wr && (w_idx == 3'd3)) r_hex <= w_hex_merged;
      if (w_rd && (w_idx == 3'd4)) r_cyc_hi_snap <= r_timer[63:32];
    end
  end

  assign o_led     = r_led;
  assign o_hex_out = r_hex;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard-style bench for mmio_responder with a short debounce period.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  byte_sel = 2'b00;
  logic [31:0] address = 32'h0, write_data = 32'h0;
  logic [15:0] switches = 16'h0;
  logic [3:0]  buttons = 4'h0;
  logic        hit;
  logic [31:0] read_data, hex_out;
  logic [15:0] led;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [63:0] cyc = 64'd0;
  logic [63:0] smp_cyc;

  mmio_responder #(.DEBOUNCE_CYCLES(4), .BASE_ADDR(32'h0000_8000)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mem_read  (mem_read),
    .i_mem_write (mem_write),
    .i_byte_sel  (byte_sel),
    .i_address   (address),
    .i_write_data(write_data),
    .i_switches  (switches),
    .i_buttons   (buttons),
    .o_hit       (hit),
    .o_read_data (read_data),
    .o_led       (led),
    .o_hex_out   (hex_out)
  );

  always #5 clk = ~clk;

  // Reference timer: value the DUT timer should hold during the current cycle.
  always @(posedge clk) cyc <= rst_n ? cyc + 64'd1 : 64'd0;

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    address = addr; mem_read = 1'b1; mem_write = 1'b0;
    #1 data = read_data; smp_cyc = cyc;
    @(posedge clk);
    #1 mem_read = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] sel);
    @(negedge clk);
    address = addr; write_data = data; byte_sel = sel; mem_write = 1'b1; mem_read = 1'b0;
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs[3];
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus_read(32'h8010, d);
    exp_q.push_back(smp_cyc[31:0]);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL reset_cyc_lo got=%h want=%h", d, exp_v); end
    addrs[0] = 32'h8008; addrs[1] = 32'h800C; addrs[2] = 32'h8004;
    foreach (addrs[i]) begin
      exp_q.push_back(32'h0);
      bus_read(addrs[i], d);
      exp_v = exp_q.pop_front(); total++;
      if (d !== exp_v) begin bad++; $display("FAIL reset_read_%h got=%h want=%h", addrs[i], d, exp_v); end
    end
    total++;
    if (led !== 16'h0 || hex_out !== 32'h0) begin
      bad++; $display("FAIL reset_outputs led=%h hex=%h want=0", led, hex_out);
    end
    for (int a = 32'h8000; a < 32'h8020; a += 3) begin
      @(negedge clk) address = a;
      #1 total++;
      if (hit !== 1'b1) begin bad++; $display("FAIL hit_in_%h got=%b want=1", a, hit); end
    end
    @(negedge clk) address = 32'h801F;
    #1 total++;
    if (hit !== 1'b1) begin bad++; $display("FAIL hit_top got=%b want=1", hit); end
    @(negedge clk) address = 32'h8020;
    #1 total++;
    if (hit !== 1'b0) begin bad++; $display("FAIL hit_8020 got=%b want=0", hit); end
    @(negedge clk) address = 32'h7FFC;
    #1 total++;
    if (hit !== 1'b0) begin bad++; $display("FAIL hit_7ffc got=%b want=0", hit); end
  endtask

  task automatic test_stores();
    logic [31:0] d;
    bus_write(32'h800C, 32'hDEADBEEF, 2'b00);
    total++;
    if (hex_out !== 32'hDEADBEEF) begin bad++; $display("FAIL hex_word got=%h want=deadbeef", hex_out); end
    bus_write(32'h800D, 32'hAAAA_AA55, 2'b10);
    bus_write(32'h800E, 32'hBBBB_1234, 2'b01);
    total++;
    if (hex_out !== 32'h1234_55EF) begin bad++; $display("FAIL hex_merge got=%h want=123455ef", hex_out); end
    exp_q.push_back(32'h1234_55EF);
    bus_read(32'h800C, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL hex_readback got=%h want=%h", d, exp_v); end
    bus_write(32'h8008, 32'hFFFF_ABCD, 2'b00);
    total++;
    if (led !== 16'hABCD) begin bad++; $display("FAIL led_word got=%h want=abcd", led); end
    bus_write(32'h800B, 32'h0000_0077, 2'b10);
    bus_write(32'h8009, 32'h0000_0012, 2'b10);
    total++;
    if (led !== 16'h12CD) begin bad++; $display("FAIL led_byte got=%h want=12cd", led); end
    bus_write(32'h800F, 32'h0000_5678, 2'b01);
    total++;
    if (hex_out !== 32'h5678_55EF) begin bad++; $display("FAIL hex_half_a0 got=%h want=567855ef", hex_out); end
    bus_write(32'h800C, 32'h0000_7777, 2'b11);
    total++;
    if (hex_out !== 32'h0000_7777) begin bad++; $display("FAIL hex_sel11 got=%h want=00007777", hex_out); end
    // Read and write in the same cycle: old value on the bus, new value afterwards.
    @(negedge clk);
    address = 32'h800C; write_data = 32'hCAFE_F00D; byte_sel = 2'b00;
    mem_read = 1'b1; mem_write = 1'b1;
    exp_q.push_back(32'h0000_7777);
    #1 d = read_data;
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL rw_old got=%h want=%h", d, exp_v); end
    @(posedge clk);
    #1 mem_read = 1'b0; mem_write = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    bus_read(32'h800C, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL rw_new got=%h want=%h", d, exp_v); end
  endtask

  task automatic test_switches();
    int   first = 0;
    logic glitch_seen = 1'b0;
    @(negedge clk) switches = 16'h00A5;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk) address = 32'h8000;
      #1;
      if (read_data !== 32'h0 && read_data !== 32'h00A5) glitch_seen = 1'b1;
      if (first == 0 && read_data === 32'h00A5) first = k;
    end
    total++;
    if (first < 6 || first > 10) begin bad++; $display("FAIL sw_latency got=%0d want=6..10", first); end
    @(negedge clk) switches = 16'h00A4;
    @(negedge clk) switches = 16'h00A5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk) address = 32'h8000;
      #1;
      if (read_data !== 32'h00A5) glitch_seen = 1'b1;
    end
    total++;
    if (glitch_seen) begin bad++; $display("FAIL sw_glitch got=seen want=stable 00a5"); end
  endtask

  task automatic test_buttons();
    logic [31:0] d;
    logic        found = 1'b0, post = 1'b0;
    @(negedge clk) buttons = 4'b0100;
    repeat (30) @(posedge clk);
    exp_q.push_back(32'h4);
    bus_read(32'h8004, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL btn_evt got=%h want=%h", d, exp_v); end
    exp_q.push_back(32'h0);
    bus_read(32'h8004, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL btn_clear got=%h want=%h", d, exp_v); end
    @(negedge clk) buttons = 4'b0000;
    repeat (30) @(posedge clk);
    exp_q.push_back(32'h0);
    bus_read(32'h8004, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL btn_fall got=%h want=%h", d, exp_v); end
    // Read every cycle so the debounced rise necessarily lands on a clearing read edge.
    @(negedge clk);
    address = 32'h8004; mem_read = 1'b1; buttons = 4'b0010;
    for (int k = 0; k < 24 && !post; k++) begin
      @(negedge clk);
      #1 d = read_data;
      if (found) begin
        post = 1'b1;
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); total++;
        if (d !== exp_v) begin bad++; $display("FAIL btn_race_clear got=%h want=%h", d, exp_v); end
      end else if (d !== 32'h0) begin
        found = 1'b1;
        exp_q.push_back(32'h2);
        exp_v = exp_q.pop_front(); total++;
        if (d !== exp_v) begin bad++; $display("FAIL btn_race_set got=%h want=%h", d, exp_v); end
      end
    end
    mem_read = 1'b0;
    total++;
    if (!post) begin bad++; $display("FAIL btn_race_timeout got=found%0b want=event seen", found); end
  endtask

  task automatic test_readonly();
    logic [31:0] d;
    bus_write(32'h8000, 32'hFFFF_FFFF, 2'b00);
    bus_write(32'h8018, 32'hFFFF_FFFF, 2'b00);
    bus_write(32'h8014, 32'hFFFF_FFFF, 2'b00);
    bus_write(32'h8028, 32'h0000_1111, 2'b00);
    total++;
    if (led !== 16'h12CD || hex_out !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL ro_write led=%h hex=%h want=12cd/cafef00d", led, hex_out);
    end
    exp_q.push_back(32'h00A5);
    bus_read(32'h8000, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL ro_sw got=%h want=%h", d, exp_v); end
    exp_q.push_back(32'h0);
    bus_read(32'h8018, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL ro_8018 got=%h want=%h", d, exp_v); end
    @(negedge clk);
    address = 32'h8020; mem_read = 1'b1;
    #1 total++;
    if (read_data !== 32'h0 || hit !== 1'b0) begin
      bad++; $display("FAIL miss_read data=%h hit=%b want=0/0", read_data, hit);
    end
    @(posedge clk);
    #1 mem_read = 1'b0;
  endtask

  task automatic test_timer();
    logic [31:0] d;
    bus_read(32'h8010, d);
    exp_q.push_back(smp_cyc[31:0]);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL cyc_lo got=%h want=%h", d, exp_v); end
    exp_q.push_back(32'h0);
    bus_read(32'h8014, d);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL cyc_hi got=%h want=%h", d, exp_v); end
    // Timer held at the low-word wrap point while CYC_LO is read.
    @(negedge clk);
    force dut.r_timer = 64'h0000_0000_FFFF_FFFF;
    address = 32'h8010; mem_read = 1'b1;
    #1 d = read_data;
    exp_q.push_back(32'hFFFF_FFFF);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL cyc_lo_wrap got=%h want=%h", d, exp_v); end
    @(posedge clk);
    #1 mem_read = 1'b0;
    @(negedge clk);
    release dut.r_timer;
    address = 32'h8014; mem_read = 1'b1;
    #1 d = read_data;
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); total++;
    if (d !== exp_v) begin bad++; $display("FAIL cyc_hi_snap got=%h want=%h", d, exp_v); end
    @(posedge clk);
    #1 mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stores();
    test_switches();
    test_buttons();
    test_readonly();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
